storage_port_arbiter: RTL and testbench

Shares the single management R/W port of the `storage` SRAM block between two native requesters: port 0, the management Wishbone bridge, and port 1, a user-area requester. Each port presents a hold-until-granted command. The arbiter picks a winner round-robin, drives one registered SRAM access, and returns read data with a one-cycle valid pulse. It sits between the requesters and the `storage` `mgmt_*` port and is the only driver of that port.

---
 rtl/storage_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_storage_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/storage_port_arbiter.sv
// Two-port round-robin arbiter in front of the storage SRAM management port.
// One registered SRAM access per grant; read data returns with a one-cycle rvalid pulse.
module storage_port_arbiter #(
  parameter int RAM_BLOCKS = 2,
  parameter int AW         = 9
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic [1:0]              req_i,
  input  logic [1:0]              we_i,
  input  logic [7:0]              wmask_i,
  input  logic [2*AW-1:0]         addr_i,
  input  logic [63:0]             wdata_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              err_o,
  output logic [1:0]              rvalid_o,
  output logic [31:0]             rdata_o,
  output logic [RAM_BLOCKS-1:0]   mgmt_ena,
  output logic [RAM_BLOCKS-1:0]   mgmt_wen,
  output logic [4*RAM_BLOCKS-1:0] mgmt_wen_mask,
  output logic [7:0]              mgmt_addr,
  output logic [31:0]             mgmt_wdata,
  input  logic [32*RAM_BLOCKS-1:0] mgmt_rdata
);

  localparam int BW = (AW > 8) ? AW - 8 : 1;

  typedef enum logic [1:0] {IDLE, ACC, RD} state_e;

  state_e                  state_q, state_d;
  logic                    last_q, last_d;
  logic                    sel_q, sel_d;
  logic [BW-1:0]           blk_q, blk_d;
  logic                    rd_q, rd_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [1:0]              err_q, err_d;
  logic [1:0]              rvalid_q, rvalid_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [RAM_BLOCKS-1:0]   ena_q, ena_d;
  logic [RAM_BLOCKS-1:0]   wen_q, wen_d;
  logic [4*RAM_BLOCKS-1:0] mask_q, mask_d;
  logic [7:0]              maddr_q, maddr_d;
  logic [31:0]             mwdata_q, mwdata_d;

  logic                    sel_w;
  logic                    we_w;
  logic [3:0]              mask_w;
  logic [AW-1:0]           addr_w;
  logic [31:0]             wdata_w;
  logic [BW-1:0]           blk_w;
  logic                    oor_w;

  // Winner: on contention the port not granted last; otherwise whoever asks.
  always_comb begin
    sel_w   = (req_i == 2'b11) ? ~last_q : req_i[1];
    we_w    = sel_w ? we_i[1]              : we_i[0];
    mask_w  = sel_w ? wmask_i[7:4]         : wmask_i[3:0];
    addr_w  = sel_w ? addr_i[2*AW-1:AW]    : addr_i[AW-1:0];
    wdata_w = sel_w ? wdata_i[63:32]       : wdata_i[31:0];
    blk_w   = BW'(addr_w >> 8);
    oor_w   = (int'(blk_w) >= RAM_BLOCKS);
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    sel_d    = sel_q;
    blk_d    = blk_q;
    rd_d     = rd_q;
    gnt_d    = 2'b00;
    err_d    = 2'b00;
    rvalid_d = 2'b00;
    rdata_d  = rdata_q;
    ena_d    = '0;
    wen_d    = '0;
    mask_d   = '0;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          sel_d    = sel_w;
          blk_d    = blk_w;
          rd_d     = !we_w && !oor_w;
          gnt_d    = sel_w ? 2'b10 : 2'b01;
          err_d    = {sel_w & oor_w, ~sel_w & oor_w};
          maddr_d  = addr_w[7:0];
          mwdata_d = wdata_w;
          for (int b = 0; b < RAM_BLOCKS; b++) begin
            if (!oor_w && blk_w == BW'(b)) begin
              ena_d[b]        = 1'b1;
              wen_d[b]        = we_w;
              mask_d[4*b +: 4] = mask_w;
            end
          end
          state_d = ACC;
        end
      end
      ACC: begin
        last_d  = sel_q;
        state_d = rd_q ? RD : IDLE;
      end
      RD: begin
        for (int b = 0; b < RAM_BLOCKS; b++) begin
          if (blk_q == BW'(b)) rdata_d = mgmt_rdata[32*b +: 32];
        end
        rvalid_d = sel_q ? 2'b10 : 2'b01;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      sel_q    <= 1'b0;
      blk_q    <= '0;
      rd_q     <= 1'b0;
      gnt_q    <= 2'b00;
      err_q    <= 2'b00;
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
      ena_q    <= '0;
      wen_q    <= '0;
      mask_q   <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      blk_q    <= blk_d;
      rd_q     <= rd_d;
      gnt_q    <= gnt_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      ena_q    <= ena_d;
      wen_q    <= wen_d;
      mask_q   <= mask_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign err_o         = err_q;
  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign mgmt_ena      = ena_q;
  assign mgmt_wen      = wen_q;
  assign mgmt_wen_mask = mask_q;
  assign mgmt_addr     = maddr_q;
  assign mgmt_wdata    = mwdata_q;

endmodule

// File: tb/tb_storage_port_arbiter.sv
// Directed bench for storage_port_arbiter with a behavioural 2x256x32 SRAM behind the port.
// AW=10 so block indices 2 and 3 exercise the out-of-range path.
module tb_storage_port_arbiter;

  localparam int RB = 2;
  localparam int AW = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_i, we_i;
  logic [7:0]        wmask_i;
  logic [2*AW-1:0]   addr_i;
  logic [63:0]       wdata_i;
  logic [1:0]        gnt_o, err_o, rvalid_o;
  logic [31:0]       rdata_o;
  logic [RB-1:0]     mgmt_ena, mgmt_wen;
  logic [4*RB-1:0]   mgmt_wen_mask;
  logic [7:0]        mgmt_addr;
  logic [31:0]       mgmt_wdata;
  logic [32*RB-1:0]  mgmt_rdata;

  always #5 clk = ~clk;

  storage_port_arbiter #(.RAM_BLOCKS(RB), .AW(AW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_i(req_i), .we_i(we_i), .wmask_i(wmask_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .err_o(err_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mgmt_ena(mgmt_ena), .mgmt_wen(mgmt_wen), .mgmt_wen_mask(mgmt_wen_mask),
    .mgmt_addr(mgmt_addr), .mgmt_wdata(mgmt_wdata), .mgmt_rdata(mgmt_rdata)
  );

  // SRAM model: byte-masked write, read data registered on the enable cycle.
  logic [31:0] mem [RB][256];
  logic [31:0] sram_q [RB];

  always @(posedge clk) begin
    for (int b = 0; b < RB; b++) begin
      if (mgmt_ena[b]) begin
        sram_q[b] <= mem[b][mgmt_addr];
        for (int i = 0; i < 4; i++)
          if (mgmt_wen[b] && mgmt_wen_mask[4*b+i])
            mem[b][mgmt_addr][8*i +: 8] <= mgmt_wdata[8*i +: 8];
      end
    end
  end

  assign mgmt_rdata = {sram_q[1], sram_q[0]};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] m);
    if (p == 0) begin
      we_i[0] = we; addr_i[AW-1:0] = a; wdata_i[31:0] = d; wmask_i[3:0] = m;
    end else begin
      we_i[1] = we; addr_i[2*AW-1:AW] = a; wdata_i[63:32] = d; wmask_i[7:4] = m;
    end
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        exp_err;
    logic [1:0]  exp_ena;
    logic [31:0] exp_rdata;
  } txn_t;

  typedef struct {
    logic [1:0]  gnt;
    logic [1:0]  ena;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
  } cyc_t;

  txn_t txns [11];
  cyc_t cont [12];

  // Single-port transaction starting from an IDLE cycle.
  task automatic do_txn(input txn_t t);
    logic [1:0] oh;
    logic [7:0] low;
    oh  = (t.port == 0) ? 2'b01 : 2'b10;
    low = t.addr[7:0];
    set_port(t.port, t.we, t.addr, t.wdata, t.mask);
    req_i = oh;
    tick();
    check("txn_gnt", gnt_o, oh);
    check("txn_err", err_o, t.exp_err ? oh : 2'b00);
    check("txn_ena", mgmt_ena, t.exp_ena);
    check("txn_wen", mgmt_wen, t.we ? t.exp_ena : 2'b00);
    check("txn_addr", mgmt_addr, low);
    if (t.we) check("txn_wdata", mgmt_wdata, t.wdata);
    req_i = 2'b00;
    tick();
    check("txn_post_gnt", {gnt_o, err_o, mgmt_ena}, 0);
    check("txn_post_rvalid", rvalid_o, 2'b00);
    if (!t.we) begin
      tick();
      check("txn_rvalid", rvalid_o, t.exp_err ? 2'b00 : oh);
      if (!t.exp_err) check("txn_rdata", rdata_o, t.exp_rdata);
    end
  endtask

  initial begin
    //          port we   addr     wdata         mask  err   ena    rdata
    txns[0]  = '{0, 1'b1, 10'h005, 32'hA5A5_1234, 4'hF, 1'b0, 2'b01, 32'h0};
    txns[1]  = '{0, 1'b0, 10'h005, 32'h0,         4'hF, 1'b0, 2'b01, 32'hA5A5_1234};
    txns[2]  = '{1, 1'b1, 10'h1FF, 32'h1122_3344, 4'hF, 1'b0, 2'b10, 32'h0};
    txns[3]  = '{1, 1'b0, 10'h1FF, 32'h0,         4'hF, 1'b0, 2'b10, 32'h1122_3344};
    txns[4]  = '{0, 1'b1, 10'h020, 32'hFFFF_FFFF, 4'hF, 1'b0, 2'b01, 32'h0};
    txns[5]  = '{0, 1'b1, 10'h020, 32'h0000_0000, 4'h5, 1'b0, 2'b01, 32'h0};
    txns[6]  = '{0, 1'b0, 10'h020, 32'h0,         4'hF, 1'b0, 2'b01, 32'hFF00_FF00};
    txns[7]  = '{1, 1'b0, 10'h205, 32'h0,         4'hF, 1'b1, 2'b00, 32'h0};
    txns[8]  = '{0, 1'b1, 10'h305, 32'hDEAD_BEEF, 4'hF, 1'b1, 2'b00, 32'h0};
    txns[9]  = '{1, 1'b1, 10'h1FF, 32'hAABB_CCDD, 4'hA, 1'b0, 2'b10, 32'h0};
    txns[10] = '{1, 1'b0, 10'h1FF, 32'h0,         4'hF, 1'b0, 2'b10, 32'hAA22_CC44};

    //          gnt    ena    rvalid rdata
    cont[0]  = '{2'b01, 2'b01, 2'b00, 32'h0};
    cont[1]  = '{2'b00, 2'b00, 2'b00, 32'h0};
    cont[2]  = '{2'b00, 2'b00, 2'b01, 32'h0A10};
    cont[3]  = '{2'b10, 2'b10, 2'b00, 32'h0A10};
    cont[4]  = '{2'b00, 2'b00, 2'b00, 32'h0A10};
    cont[5]  = '{2'b00, 2'b00, 2'b10, 32'h1B10};
    cont[6]  = '{2'b01, 2'b01, 2'b00, 32'h1B10};
    cont[7]  = '{2'b00, 2'b00, 2'b00, 32'h1B10};
    cont[8]  = '{2'b00, 2'b00, 2'b01, 32'h0A10};
    cont[9]  = '{2'b10, 2'b10, 2'b00, 32'h0A10};
    cont[10] = '{2'b00, 2'b00, 2'b00, 32'h0A10};
    cont[11] = '{2'b00, 2'b00, 2'b10, 32'h1B10};

    // Reset held with both ports requesting writes that seed the contention data.
    rst_n = 1'b0;
    req_i = 2'b11;
    we_i = 2'b11; wmask_i = 8'hFF; addr_i = '0; wdata_i = '0;
    set_port(0, 1'b1, 10'h010, 32'h0A10, 4'hF);
    set_port(1, 1'b1, 10'h110, 32'h1B10, 4'hF);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_pulses", {gnt_o, err_o, rvalid_o, mgmt_ena, mgmt_wen, mgmt_wen_mask}, 0);
      check("rst_data", {rdata_o, mgmt_wdata}, 0);
      check("rst_addr", mgmt_addr, 8'h00);
    end
    rst_n = 1'b1;
    tick();
    check("rel_gnt0", gnt_o, 2'b01);
    check("rel_ena0", mgmt_ena, 2'b01);
    check("rel_wen0", mgmt_wen, 2'b01);
    req_i = 2'b10;
    tick();
    check("rel_idle_gnt", gnt_o, 2'b00);
    tick();
    check("rel_gnt1", gnt_o, 2'b10);
    check("rel_ena1", mgmt_ena, 2'b10);
    check("rel_wdata1", mgmt_wdata, 32'h1B10);
    req_i = 2'b00;
    tick();

    // Contention: both ports hold reads; grants alternate starting with port 0.
    set_port(0, 1'b0, 10'h010, 32'h0, 4'hF);
    set_port(1, 1'b0, 10'h110, 32'h0, 4'hF);
    req_i = 2'b11;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("cont_gnt_c%0d", i), gnt_o, cont[i].gnt);
      check($sformatf("cont_ena_c%0d", i), mgmt_ena, cont[i].ena);
      check($sformatf("cont_rvalid_c%0d", i), rvalid_o, cont[i].rvalid);
      check($sformatf("cont_rdata_c%0d", i), rdata_o, cont[i].rdata);
      if (cont[i].gnt != 2'b00) check($sformatf("cont_addr_c%0d", i), mgmt_addr, 8'h10);
    end
    req_i = 2'b00;
    tick();
    check("cont_quiet", gnt_o, 2'b00);

    for (int i = 0; i < 11; i++) do_txn(txns[i]);

    // Reset asserted during RD: the read is dropped and rdata_o clears.
    set_port(0, 1'b0, 10'h005, 32'h0, 4'hF);
    req_i = 2'b01;
    tick();
    check("mid_gnt", gnt_o, 2'b01);
    req_i = 2'b00;
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rvalid", rvalid_o, 2'b00);
    check("mid_rdata", rdata_o, 32'h0);
    check("mid_outs", {gnt_o, mgmt_ena}, 0);
    rst_n = 1'b1;
    tick();
    check("mid_rvalid_after", rvalid_o, 2'b00);
    do_txn(txns[10]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
